// File: rtl/sync_checker.sv
// ---------------------------------------------------------------------------
// sync_checker
//
// Watches a one-cycle strobe train, typically the carry of a modulo counter.
// It measures the strobe-to-strobe interval and compares it with the
// expected interval `modul`. After LOCK_HITS consecutive matching intervals
// it declares lock. A wrong interval pulses `err`. A strobe that is overdue
// pulses `miss` and drops the checker back to waiting for a reference strobe.
//
// Parameters
//   N          width of period / phase / modul values
//   LOCK_HITS  consecutive matching intervals required for lock (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   strobe        one-cycle sync pulse, synchronous to clk
//   modul [N]     expected strobe interval in clk cycles (0 = checking off)
//   period [N]    last measured strobe-to-strobe interval
//   period_valid  one-cycle pulse when period is updated
//   locked        level, strobe train currently matches modul
//   err           one-cycle pulse, measured interval differs from modul
//   miss          one-cycle pulse, no strobe within modul cycles
//   phase [N]     cycles elapsed since the last strobe
//
// Every output is a register. A strobe sampled at edge t is reflected
// in the outputs right after edge t.
// ---------------------------------------------------------------------------
module sync_checker #(
    parameter int N         = 28,
    parameter int LOCK_HITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe,
    input  logic [N-1:0] modul,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         err,
    output logic         miss,
    output logic [N-1:0] phase
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_MAX     = {N{1'b1}};
    localparam logic [N-1:0] CNT_ZERO    = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [3:0]   LOCK_TARGET = 4'(LOCK_HITS);

    // Saturating increment. Once it reaches all-ones, the value sticks there.
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] value);
        logic [N-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    state_t         state_r;
    logic [N-1:0]   cnt_r;
    logic [3:0]     hits_r;
    logic [N-1:0]   period_r;
    logic           period_valid_r;
    logic           locked_r;
    logic           err_r;
    logic           miss_r;

    logic [N-1:0]   interval_s;
    logic           match_s;
    logic           overdue_s;
    logic [3:0]     hits_inc_s;

    // The interval for a strobe in this cycle is cnt+1, because cnt restarts at 0
    // on the cycle after a strobe.
    assign interval_s = sat_inc(cnt_r);
    assign match_s    = (interval_s == modul);
    // An arriving strobe takes priority over the overdue test. So a strobe at
    // cnt==modul counts as a late strobe (mismatch), not as a miss.
    assign overdue_s  = (!strobe) && (cnt_r == modul);
    assign hits_inc_s = hits_r + 4'd1;

    // Phase counter: restarts on every strobe and saturates at all-ones.
    // It runs independently of the checker state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (strobe) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= sat_inc(cnt_r);
        end
    end

    // Acquisition / lock state machine and its registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            hits_r         <= 4'd0;
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            err_r          <= 1'b0;
            miss_r         <= 1'b0;
        end else begin
            period_valid_r <= 1'b0;
            err_r          <= 1'b0;
            miss_r         <= 1'b0;
            if (modul == CNT_ZERO) begin
                // No expected interval: hold the checker disarmed.
                state_r  <= ST_IDLE;
                hits_r   <= 4'd0;
                locked_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // The first strobe only provides a reference point.
                        // There is no interval to report yet.
                        if (strobe) begin
                            state_r <= ST_ACQ;
                            hits_r  <= 4'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                        locked_r <= 1'b0;
                    end
                    ST_ACQ: begin
                        if (strobe) begin
                            period_r       <= interval_s;
                            period_valid_r <= 1'b1;
                            if (match_s) begin
                                hits_r <= hits_inc_s;
                                if (hits_inc_s == LOCK_TARGET) begin
                                    state_r  <= ST_LOCKED;
                                    locked_r <= 1'b1;
                                end else begin
                                    state_r  <= ST_ACQ;
                                    locked_r <= 1'b0;
                                end
                            end else begin
                                err_r    <= 1'b1;
                                hits_r   <= 4'd0;
                                state_r  <= ST_ACQ;
                                locked_r <= 1'b0;
                            end
                        end else if (overdue_s) begin
                            miss_r   <= 1'b1;
                            hits_r   <= 4'd0;
                            locked_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r <= ST_ACQ;
                        end
                    end
                    ST_LOCKED: begin
                        if (strobe) begin
                            period_r       <= interval_s;
                            period_valid_r <= 1'b1;
                            if (match_s) begin
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                err_r    <= 1'b1;
                                hits_r   <= 4'd0;
                                locked_r <= 1'b0;
                                state_r  <= ST_ACQ;
                            end
                        end else if (overdue_s) begin
                            miss_r   <= 1'b1;
                            hits_r   <= 4'd0;
                            locked_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r <= ST_LOCKED;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover to a safe, unlocked state.
                        state_r  <= ST_IDLE;
                        hits_r   <= 4'd0;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign err          = err_r;
    assign miss         = miss_r;
    assign phase        = cnt_r;

endmodule

// File: tb/tb_sync_checker.sv
module tb_sync_checker;

    localparam int TB_N  = 8;
    localparam int HITS  = 4;
    localparam int MAXV  = (1 << TB_N) - 1;

    logic            clk;
    logic            reset;
    logic            strobe;
    logic [TB_N-1:0] modul;
    logic [TB_N-1:0] period;
    logic            period_valid;
    logic            locked;
    logic            err;
    logic            miss;
    logic [TB_N-1:0] phase;

    sync_checker #(.N(TB_N), .LOCK_HITS(HITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .modul        (modul),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err),
        .miss         (miss),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model. It tracks absolute edge numbers and works out the
    // expected outputs from the time elapsed since the last strobe.
    int edge_no    = 0;
    int last_edge  = 0;
    bit armed      = 1'b0;
    int run        = 0;
    bit lk         = 1'b0;
    int exp_period = 0;
    bit exp_pv     = 1'b0;
    bit exp_err    = 1'b0;
    bit exp_miss   = 1'b0;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".period"},       32'(period),       32'(exp_period));
        chk({tag, ".period_valid"}, 32'(period_valid), 32'(exp_pv));
        chk({tag, ".locked"},       32'(locked),       32'(lk));
        chk({tag, ".err"},          32'(err),          32'(exp_err));
        chk({tag, ".miss"},         32'(miss),         32'(exp_miss));
        chk({tag, ".phase"},        32'(phase),        32'(sat(edge_no - last_edge)));
    endtask

    task automatic model_edge(input bit s, input int m);
        int prev;
        int iv;
        edge_no++;
        prev     = sat(edge_no - 1 - last_edge);
        iv       = sat(edge_no - last_edge);
        exp_pv   = 1'b0;
        exp_err  = 1'b0;
        exp_miss = 1'b0;
        if (m == 0) begin
            armed = 1'b0; run = 0; lk = 1'b0;
        end else if (s) begin
            if (!armed) begin
                armed = 1'b1; run = 0;
            end else begin
                exp_period = iv;
                exp_pv     = 1'b1;
                if (iv == m) begin
                    if (!lk) begin
                        run++;
                        if (run == HITS) lk = 1'b1;
                    end
                end else begin
                    exp_err = 1'b1; run = 0; lk = 1'b0;
                end
            end
        end else if (armed && prev == m) begin
            exp_miss = 1'b1; armed = 1'b0; lk = 1'b0; run = 0;
        end
        if (s) last_edge = edge_no;
    endtask

    // One clock: drive inputs, take the edge, advance the model, check #1 later.
    task automatic step(input bit s, input int m);
        strobe = s;
        modul  = TB_N'(m);
        @(posedge clk);
        model_edge(s, m);
        #1;
        check_all("step");
    endtask

    task automatic train(input int m, input int gap, input int count);
        for (int k = 0; k < count; k++) begin
            for (int z = 1; z < gap; z++) step(1'b0, m);
            step(1'b1, m);
        end
    endtask

    task automatic pulse_reset();
        #3;
        reset = 1'b0;
        armed = 1'b0; run = 0; lk = 1'b0;
        exp_period = 0; exp_pv = 1'b0; exp_err = 1'b0; exp_miss = 1'b0;
        last_edge = edge_no;
        #1;
        check_all("async_reset");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0;
        reset  = 1'b1;
    endtask

    initial begin
        int m;
        int gap;
        reset  = 1'b0;
        strobe = 1'b0;
        modul  = TB_N'(0);
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Lock on a clean train at modul=5.
        train(5, 5, 4);
        chk("lock_not_yet", 32'(locked), 32'd0);
        train(5, 5, 1);
        chk("lock_after_5th", 32'(locked), 32'd1);
        train(5, 5, 3);

        // A short interval breaks lock, and 4 good intervals relock.
        train(5, 4, 1);
        chk("short_err", 32'(err), 32'd1);
        chk("short_unlock", 32'(locked), 32'd0);
        train(5, 5, 3);
        chk("relock_pending", 32'(locked), 32'd0);
        train(5, 5, 1);
        chk("relocked", 32'(locked), 32'd1);

        // Strobes stop: miss fires one cycle after phase reaches 5.
        for (int z = 0; z < 5; z++) step(1'b0, 5);
        chk("phase_at_modul", 32'(phase), 32'd5);
        chk("no_miss_yet", 32'(miss), 32'd0);
        step(1'b0, 5);
        chk("miss_pulse", 32'(miss), 32'd1);
        step(1'b0, 5);
        chk("miss_one_cycle", 32'(miss), 32'd0);
        train(5, 5, 1);
        chk("rearm_silent", 32'(period_valid), 32'd0);
        train(5, 5, 1);
        chk("second_valid", 32'(period_valid), 32'd1);

        // A strobe exactly at cnt==modul counts as a mismatch, not a miss.
        train(5, 6, 1);
        chk("late_err", 32'(err), 32'd1);
        chk("late_nomiss", 32'(miss), 32'd0);
        chk("late_period", 32'(period), 32'd6);

        // With modul=0 the checker is off while phase keeps running.
        for (int k = 0; k < 40; k++) step(($urandom_range(0, 3) == 0), 0);

        // Random trains around modul, with occasional modul changes.
        m = 5;
        for (int k = 0; k < 70; k++) begin
            if ($urandom_range(0, 9) == 0) m = $urandom_range(3, 8);
            if ($urandom_range(0, 2) == 0) gap = $urandom_range(m - 1, m + 2);
            else gap = m;
            train(m, gap, 1);
        end

        // Lock, then pulse reset in the middle of an interval.
        train(6, 6, 6);
        step(1'b0, 6);
        step(1'b0, 6);
        pulse_reset();
        train(6, 6, HITS);
        chk("post_reset_not_locked", 32'(locked), 32'd0);
        train(6, 6, 1);
        chk("post_reset_locked", 32'(locked), 32'd1);

        // Phase saturation, and misses at large modul values.
        step(1'b1, 200);
        for (int z = 0; z < 299; z++) step(1'b0, 200);
        chk("phase_sat", 32'(phase), 32'(MAXV));
        step(1'b1, 200);
        for (int z = 0; z < 270; z++) step(1'b0, MAXV);
        step(1'b1, MAXV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
